// File: rtl/frame_rate_monitor_pkg.sv
// Shared FSM encoding and status-word layout for the frame rate monitor.
package frame_rate_monitor_pkg;

    typedef enum logic [1:0] {
        ST_DISABLED = 2'd0,
        ST_ARM      = 2'd1,
        ST_COUNT    = 2'd2
    } fsm_state_t;

    localparam int unsigned WORD_W    = 32;
    localparam int unsigned VALID_BIT = 31;
    localparam int unsigned STALL_BIT = 30;
    localparam int unsigned SEQ_LSB   = 16;
    localparam int unsigned SEQ_W     = 8;
    localparam int unsigned COUNT_LSB = 0;
    localparam int unsigned COUNT_W   = 16;
    localparam int unsigned EMPTY_W   = 8;

endpackage

// File: rtl/fps_edge_detect.sv
// Registers vsync and emits a one-cycle frame_start on the selected edge.
module fps_edge_detect #(
    parameter int unsigned VSYNC_POL = 1
) (
    input  logic clk,
    input  logic resetn,
    input  logic vsync,
    output logic frame_start
);

    localparam bit RISING = (VSYNC_POL != 0);

    logic vsync_q;
    logic edge_c;

    // Edge of interest, compared against the previous vsync sample.
    always_comb begin
        edge_c = RISING ? (vsync & ~vsync_q) : (~vsync & vsync_q);
    end

    // Sample vsync and register the pulse (one cycle after the change).
    always_ff @(posedge clk) begin
        if (!resetn) begin
            vsync_q     <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            vsync_q     <= vsync;
            frame_start <= edge_c;
        end
    end

endmodule

// File: rtl/frame_rate_monitor.sv
// Counts frame starts per one-second window and measures the frame period.
module frame_rate_monitor
    import frame_rate_monitor_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ   = 100_000_000,
    parameter int unsigned CNT_WIDTH     = 16,
    parameter int unsigned VSYNC_POL     = 1,
    parameter int unsigned STALL_WINDOWS = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        enable,
    input  logic        vsync,
    output logic [31:0] frames_per_second,
    output logic [31:0] frame_period,
    output logic        fps_update
);

    localparam int unsigned TMR_W = $clog2(CLK_FREQ_HZ + 1);
    localparam logic [TMR_W-1:0]     TMR_LAST = TMR_W'(CLK_FREQ_HZ - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [EMPTY_W-1:0]   STALL_TH = EMPTY_W'(STALL_WINDOWS);

    fsm_state_t           state_q, state_d;
    logic                 frame_start;
    logic [TMR_W-1:0]     timer_q;
    logic [CNT_WIDTH-1:0] run_cnt_q;
    logic [EMPTY_W-1:0]   empty_q;
    logic [31:0]          period_cnt_q;

    logic                 start_c;
    logic                 close_c;
    logic                 clear_c;
    logic [CNT_WIDTH-1:0] cnt_now_c;
    logic [EMPTY_W-1:0]   empty_now_c;

    fps_edge_detect #(
        .VSYNC_POL (VSYNC_POL)
    ) u_edge (
        .clk         (clk),
        .resetn      (resetn),
        .vsync       (vsync),
        .frame_start (frame_start)
    );

    // Next state and per-cycle control; disable overrides everything.
    always_comb begin
        state_d = state_q;
        start_c = 1'b0;
        close_c = 1'b0;
        clear_c = 1'b0;
        case (state_q)
            ST_DISABLED: begin
                if (enable) state_d = ST_ARM;
            end
            ST_ARM: begin
                if (frame_start) begin
                    state_d = ST_COUNT;
                    start_c = 1'b1;
                end
            end
            ST_COUNT: begin
                if (timer_q == TMR_LAST) close_c = 1'b1;
            end
            default: state_d = ST_DISABLED;
        endcase
        if (!enable) begin
            state_d = ST_DISABLED;
            start_c = 1'b0;
            close_c = 1'b0;
            clear_c = 1'b1;
        end
    end

    // Running count including this cycle's frame (saturating), and the
    // empty-window tally that would result if the window closed now.
    always_comb begin
        cnt_now_c = run_cnt_q;
        if ((state_q == ST_COUNT) && frame_start && (run_cnt_q != CNT_MAX))
            cnt_now_c = run_cnt_q + CNT_WIDTH'(1);
        if (cnt_now_c != '0)
            empty_now_c = '0;
        else if (empty_q == '1)
            empty_now_c = empty_q;
        else
            empty_now_c = empty_q + EMPTY_W'(1);
    end

    // State register, window timer, period measurement and publishing.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q           <= ST_DISABLED;
            timer_q           <= '0;
            run_cnt_q         <= '0;
            empty_q           <= '0;
            period_cnt_q      <= '0;
            frames_per_second <= '0;
            frame_period      <= '0;
            fps_update        <= 1'b0;
        end else begin
            state_q    <= state_d;
            fps_update <= 1'b0;
            if (clear_c) begin
                timer_q                      <= '0;
                run_cnt_q                    <= '0;
                empty_q                      <= '0;
                period_cnt_q                 <= '0;
                frames_per_second[VALID_BIT] <= 1'b0;
            end else if (start_c) begin
                // Arming frame: frame 1 of window 1, timer was 0 this cycle.
                timer_q      <= TMR_W'(1);
                run_cnt_q    <= CNT_WIDTH'(1);
                period_cnt_q <= 32'd1;
            end else if (state_q == ST_COUNT) begin
                if (frame_start) begin
                    frame_period <= period_cnt_q;
                    period_cnt_q <= 32'd1;
                end else if (period_cnt_q != 32'hFFFF_FFFF) begin
                    period_cnt_q <= period_cnt_q + 32'd1;
                end
                if (close_c) begin
                    timer_q   <= '0;
                    run_cnt_q <= '0;
                    empty_q   <= empty_now_c;
                    frames_per_second[COUNT_LSB +: COUNT_W] <= COUNT_W'(cnt_now_c);
                    frames_per_second[SEQ_LSB +: SEQ_W] <=
                        frames_per_second[SEQ_LSB +: SEQ_W] + SEQ_W'(1);
                    frames_per_second[VALID_BIT] <= 1'b1;
                    frames_per_second[STALL_BIT] <= (empty_now_c >= STALL_TH);
                    fps_update <= 1'b1;
                end else begin
                    timer_q   <= timer_q + TMR_W'(1);
                    run_cnt_q <= cnt_now_c;
                end
            end
        end
    end

endmodule
